bram1be_rr_arbiter: RTL and testbench

//  Shares one single-ported byte-enable BRAM (EN/WE/ADDR/DI/DO) between two requesters, A and B.
//  - Arbitration is round-robin.
//  - Each accepted read returns its data to the requester that issued it, after the BRAM's fixed latency.
//  - Write responses are discarded. The controller sits between client logic and the BRAM instance.

---
 rtl/bram_arb_pkg.sv | 20 ++
 rtl/bram_rr_arb2.sv | 38 +++
 rtl/bram1be_rr_arbiter.sv | 95 +++++++++
 tb/tb_bram1be_rr_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the BRAM port arbiters.
// Covers client identifiers, read-tag records and the BRAM read latency.
package bram_arb_pkg;

    typedef enum logic {
        CLIENT_A = 1'b0,
        CLIENT_B = 1'b1
    } client_id_t;

    typedef struct packed {
        logic       vld;
        client_id_t id;
    } tag_t;

    // A pipelined BRAM adds an output register, so reads take one cycle longer.
    function automatic int lat(input int pipelined);
        return (pipelined != 0) ? 2 : 1;
    endfunction

endpackage

// File: rtl/bram_rr_arb2.sv
// Two-way round-robin grant.
// On a tie, the requester that did not win last time is granted.
module bram_rr_arb2 (
    input  logic CLK,
    input  logic RST_N,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);
    import bram_arb_pkg::*;

    client_id_t last_grant;

    // Grants are held low during reset so nothing reaches the BRAM.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (RST_N) begin
            if (req_a && (!req_b || last_grant == CLIENT_B)) begin
                gnt_a = 1'b1;
            end else if (req_b) begin
                gnt_b = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            last_grant <= CLIENT_B;
        end else if (gnt_a) begin
            last_grant <= CLIENT_A;
        end else if (gnt_b) begin
            last_grant <= CLIENT_B;
        end
    end

endmodule

// File: rtl/bram1be_rr_arbiter.sv
// Shares one single-ported byte-enable BRAM between requesters A and B.
// Each read returns its data to its issuer after the BRAM's fixed latency.
module bram1be_rr_arbiter #(
    parameter int ADDR_WIDTH = 1,
    parameter int DATA_WIDTH = 8,
    parameter int CHUNKSIZE  = 8,
    parameter int WE_WIDTH   = 1,
    parameter int PIPELINED  = 0
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  a_req_valid,
    output logic                  a_req_ready,
    input  logic [WE_WIDTH-1:0]   a_req_we,
    input  logic [ADDR_WIDTH-1:0] a_req_addr,
    input  logic [DATA_WIDTH-1:0] a_req_wdata,
    output logic                  a_rsp_valid,
    output logic [DATA_WIDTH-1:0] a_rsp_rdata,
    input  logic                  b_req_valid,
    output logic                  b_req_ready,
    input  logic [WE_WIDTH-1:0]   b_req_we,
    input  logic [ADDR_WIDTH-1:0] b_req_addr,
    input  logic [DATA_WIDTH-1:0] b_req_wdata,
    output logic                  b_rsp_valid,
    output logic [DATA_WIDTH-1:0] b_rsp_rdata,
    output logic                  bram_en,
    output logic [WE_WIDTH-1:0]   bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_di,
    input  logic [DATA_WIDTH-1:0] bram_do
);
    import bram_arb_pkg::*;

    localparam int LAT = lat(PIPELINED);

    if (DATA_WIDTH != WE_WIDTH * CHUNKSIZE) begin : g_bad_lane_cfg
        $error("DATA_WIDTH must equal WE_WIDTH*CHUNKSIZE");
    end

    tag_t tag_q [LAT];
    tag_t tag_in;
    tag_t tag_out;

    bram_rr_arb2 u_arb (
        .CLK   (CLK),
        .RST_N (RST_N),
        .req_a (a_req_valid),
        .req_b (b_req_valid),
        .gnt_a (a_req_ready),
        .gnt_b (b_req_ready)
    );

    assign bram_en = a_req_ready | b_req_ready;

    always_comb begin
        bram_we   = '0;
        bram_addr = '0;
        bram_di   = '0;
        if (a_req_ready) begin
            bram_we   = a_req_we;
            bram_addr = a_req_addr;
            bram_di   = a_req_wdata;
        end else if (b_req_ready) begin
            bram_we   = b_req_we;
            bram_addr = b_req_addr;
            bram_di   = b_req_wdata;
        end
    end

    // Only reads earn a tag, so the BRAM's DO change after a write is never returned.
    always_comb begin
        tag_in.vld = (a_req_ready && a_req_we == '0) || (b_req_ready && b_req_we == '0);
        tag_in.id  = b_req_ready ? CLIENT_B : CLIENT_A;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= tag_in;
            for (int i = 1; i < LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign tag_out     = tag_q[LAT-1];
    assign a_rsp_valid = tag_out.vld && (tag_out.id == CLIENT_A);
    assign b_rsp_valid = tag_out.vld && (tag_out.id == CLIENT_B);
    assign a_rsp_rdata = bram_do;
    assign b_rsp_rdata = bram_do;

endmodule

// File: tb/tb_bram1be_rr_arbiter.sv
// Bench for bram1be_rr_arbiter: a non-pipelined and a pipelined instance share
// the same stimulus, each attached to its own byte-enable write-first BRAM model.
module tb_bram1be_rr_arbiter;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int CW = 8;
    localparam int WW = 2;

    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    logic          a_valid, b_valid;
    logic [WW-1:0] a_we, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;

    logic [1:0]         a_ready, b_ready, a_rv, b_rv, en;
    logic [1:0][WW-1:0] we_o;
    logic [1:0][AW-1:0] addr_o;
    logic [1:0][DW-1:0] di_o, do_i, a_rd, b_rd;

    for (genvar p = 0; p < 2; p++) begin : g_inst
        logic [DW-1:0] mem [16];
        logic [DW-1:0] do1, do2, merged;

        bram1be_rr_arbiter #(
            .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CHUNKSIZE(CW),
            .WE_WIDTH(WW), .PIPELINED(p)
        ) dut (
            .CLK(CLK), .RST_N(RST_N),
            .a_req_valid(a_valid), .a_req_ready(a_ready[p]), .a_req_we(a_we),
            .a_req_addr(a_addr), .a_req_wdata(a_wdata),
            .a_rsp_valid(a_rv[p]), .a_rsp_rdata(a_rd[p]),
            .b_req_valid(b_valid), .b_req_ready(b_ready[p]), .b_req_we(b_we),
            .b_req_addr(b_addr), .b_req_wdata(b_wdata),
            .b_rsp_valid(b_rv[p]), .b_rsp_rdata(b_rd[p]),
            .bram_en(en[p]), .bram_we(we_o[p]), .bram_addr(addr_o[p]),
            .bram_di(di_o[p]), .bram_do(do_i[p])
        );

        always_comb begin
            merged = mem[addr_o[p]];
            if (we_o[p][0]) merged[7:0]  = di_o[p][7:0];
            if (we_o[p][1]) merged[15:8] = di_o[p][15:8];
        end

        // Write-first BRAM; the pipelined variant adds an output register.
        always @(posedge CLK) begin
            if (en[p]) begin
                if (we_o[p] != '0) begin
                    mem[addr_o[p]] <= merged;
                    do1            <= merged;
                end else begin
                    do1 <= mem[addr_o[p]];
                end
            end
            do2 <= do1;
        end

        assign do_i[p] = (p == 1) ? do2 : do1;
    end

    typedef struct {
        logic          av;
        logic [WW-1:0] awe;
        logic [AW-1:0] aaddr;
        logic [DW-1:0] awd;
        logic          bv;
        logic [WW-1:0] bwe;
        logic [AW-1:0] baddr;
        logic [DW-1:0] bwd;
        logic          exp_a;
        logic          exp_b;
    } vec_t;

    typedef struct {
        logic          id;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    vec_t vecs[$];
    exp_t q0[$], q1[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic          tbl_chk, tbl_exp_a, tbl_exp_b;
    logic          last_is_b;
    logic [DW-1:0] shadow [16];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(
        input logic av, input logic [WW-1:0] awe, input logic [AW-1:0] aaddr, input logic [DW-1:0] awd,
        input logic bv, input logic [WW-1:0] bwe, input logic [AW-1:0] baddr, input logic [DW-1:0] bwd,
        input logic chk, input logic ea, input logic eb);
        @(posedge CLK);
        #1;
        a_valid = av; a_we = awe; a_addr = aaddr; a_wdata = awd;
        b_valid = bv; b_we = bwe; b_addr = baddr; b_wdata = bwd;
        tbl_chk = chk; tbl_exp_a = ea; tbl_exp_b = eb;
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    endtask

    function automatic logic [DW-1:0] mergeWrite(input logic [DW-1:0] old, input logic [WW-1:0] we,
                                                 input logic [DW-1:0] di);
        logic [DW-1:0] r;
        r = old;
        if (we[0]) r[7:0]  = di[7:0];
        if (we[1]) r[15:8] = di[15:8];
        return r;
    endfunction

    // Reference model: round-robin grant, shadow memory and read scoreboard.
    task automatic monitorCycle();
        logic          ga, gb;
        logic [WW-1:0] g_we;
        logic [AW-1:0] g_addr;
        logic [DW-1:0] g_di;
        logic [1:0]    ev_a, ev_b;
        logic [1:0][DW-1:0] ed;
        exp_t e;
        cyc++;
        if (!RST_N) begin
            q0.delete();
            q1.delete();
            last_is_b = 1'b1;
            for (int p = 0; p < 2; p++) begin
                checkOutput($sformatf("p%0d_rst_a_ready", p), a_ready[p], 0);
                checkOutput($sformatf("p%0d_rst_b_ready", p), b_ready[p], 0);
                checkOutput($sformatf("p%0d_rst_bram_en", p), en[p], 0);
                checkOutput($sformatf("p%0d_rst_a_rsp_valid", p), a_rv[p], 0);
                checkOutput($sformatf("p%0d_rst_b_rsp_valid", p), b_rv[p], 0);
            end
            return;
        end

        ga = a_valid && (!b_valid || last_is_b);
        gb = b_valid && (!a_valid || !last_is_b);
        g_we   = ga ? a_we    : (gb ? b_we    : '0);
        g_addr = ga ? a_addr  : (gb ? b_addr  : '0);
        g_di   = ga ? a_wdata : (gb ? b_wdata : '0);

        ev_a = '0; ev_b = '0; ed = '0;
        if (q0.size() > 0 && q0[0].due == cyc) begin
            e = q0.pop_front();
            if (e.id) ev_b[0] = 1'b1; else ev_a[0] = 1'b1;
            ed[0] = e.data;
        end
        if (q1.size() > 0 && q1[0].due == cyc) begin
            e = q1.pop_front();
            if (e.id) ev_b[1] = 1'b1; else ev_a[1] = 1'b1;
            ed[1] = e.data;
        end

        for (int p = 0; p < 2; p++) begin
            if (tbl_chk) begin
                checkOutput($sformatf("p%0d_tbl_a_ready", p), a_ready[p], tbl_exp_a);
                checkOutput($sformatf("p%0d_tbl_b_ready", p), b_ready[p], tbl_exp_b);
            end
            checkOutput($sformatf("p%0d_a_ready", p), a_ready[p], ga);
            checkOutput($sformatf("p%0d_b_ready", p), b_ready[p], gb);
            checkOutput($sformatf("p%0d_bram_en", p), en[p], ga | gb);
            checkOutput($sformatf("p%0d_bram_we", p), we_o[p], g_we);
            checkOutput($sformatf("p%0d_bram_addr", p), addr_o[p], g_addr);
            checkOutput($sformatf("p%0d_bram_di", p), di_o[p], g_di);
            checkOutput($sformatf("p%0d_a_rsp_valid", p), a_rv[p], ev_a[p]);
            checkOutput($sformatf("p%0d_b_rsp_valid", p), b_rv[p], ev_b[p]);
            if (ev_a[p]) checkOutput($sformatf("p%0d_a_rsp_rdata", p), a_rd[p], ed[p]);
            if (ev_b[p]) checkOutput($sformatf("p%0d_b_rsp_rdata", p), b_rd[p], ed[p]);
        end

        if (ga || gb) begin
            last_is_b = gb;
            if (g_we == '0) begin
                q0.push_back('{id: gb, data: shadow[g_addr], due: cyc + 1});
                q1.push_back('{id: gb, data: shadow[g_addr], due: cyc + 2});
            end else begin
                shadow[g_addr] = mergeWrite(shadow[g_addr], g_we, g_di);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            monitorCycle();
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RST_N = 1'b0;
        a_valid = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_valid = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        tbl_chk = 0; tbl_exp_a = 0; tbl_exp_b = 0;
        last_is_b = 1'b1;
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;

        // {av, awe, aaddr, awd, bv, bwe, baddr, bwd, exp_a_ready, exp_b_ready}
        vecs.push_back('{1, 2'b11, 3, 16'h00A5, 0, 0, 0, 0, 1, 0});
        vecs.push_back('{1, 2'b00, 3, 16'h0000, 0, 0, 0, 0, 1, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{1, 2'b11, 5, 16'h1234, 0, 0, 0, 0, 1, 0});
        vecs.push_back('{1, 2'b01, 5, 16'hFFCD, 0, 0, 0, 0, 1, 0});
        vecs.push_back('{1, 2'b00, 5, 16'h0000, 0, 0, 0, 0, 1, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{1, 2'b11, 7, 16'hBEEF, 0, 0, 0, 0, 1, 0});
        vecs.push_back('{0, 0, 0, 0, 1, 2'b00, 7, 16'h0000, 0, 1});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{1, 2'b11, 8,  16'h8888, 1, 2'b11, 12, 16'hCCCC, 1, 0});
        vecs.push_back('{1, 2'b11, 8,  16'h8888, 1, 2'b11, 12, 16'hCCCC, 0, 1});
        vecs.push_back('{1, 2'b11, 9,  16'h9999, 1, 2'b11, 13, 16'hDDDD, 1, 0});
        vecs.push_back('{1, 2'b11, 9,  16'h9999, 1, 2'b11, 13, 16'hDDDD, 0, 1});
        vecs.push_back('{1, 2'b11, 10, 16'hAAAA, 1, 2'b11, 14, 16'hEEEE, 1, 0});
        vecs.push_back('{1, 2'b11, 10, 16'hAAAA, 1, 2'b11, 14, 16'hEEEE, 0, 1});
        vecs.push_back('{1, 2'b11, 11, 16'hBBBB, 1, 2'b11, 15, 16'hFFFF, 1, 0});
        vecs.push_back('{1, 2'b11, 11, 16'hBBBB, 1, 2'b11, 15, 16'hFFFF, 0, 1});
        vecs.push_back('{1, 2'b00, 8,  0, 1, 2'b00, 12, 0, 1, 0});
        vecs.push_back('{1, 2'b00, 9,  0, 1, 2'b00, 12, 0, 0, 1});
        vecs.push_back('{1, 2'b00, 9,  0, 1, 2'b00, 13, 0, 1, 0});
        vecs.push_back('{1, 2'b00, 10, 0, 1, 2'b00, 13, 0, 0, 1});
        vecs.push_back('{1, 2'b00, 10, 0, 1, 2'b00, 14, 0, 1, 0});
        vecs.push_back('{1, 2'b00, 11, 0, 1, 2'b00, 14, 0, 0, 1});
        vecs.push_back('{1, 2'b00, 11, 0, 1, 2'b00, 15, 0, 1, 0});
        vecs.push_back('{1, 2'b00, 8,  0, 1, 2'b00, 15, 0, 0, 1});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 1, 2'b00, 12, 0, 0, 1});
        vecs.push_back('{1, 2'b00, 3, 0, 1, 2'b11, 6, 16'h0606, 1, 0});
        vecs.push_back('{0, 0, 0, 0, 1, 2'b11, 6, 16'h0606, 0, 1});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0});

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].av, vecs[i].awe, vecs[i].aaddr, vecs[i].awd,
                          vecs[i].bv, vecs[i].bwe, vecs[i].baddr, vecs[i].bwd,
                          1'b1, vecs[i].exp_a, vecs[i].exp_b);
        end

        // Two reads in flight, then reset lands before their responses complete.
        applyStimulus(1, 0, 3, 0, 0, 0, 0, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 5, 0, 1, 0, 1);
        @(posedge CLK);
        #1;
        RST_N = 1'b0;
        a_valid = 1; a_we = 0; a_addr = 3;
        b_valid = 1; b_we = 0; b_addr = 5;
        tbl_chk = 0;
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        tbl_chk = 1; tbl_exp_a = 1; tbl_exp_b = 0;
        applyStimulus(1, 0, 3, 0, 1, 0, 5, 0, 1, 0, 1);
        repeat (5) idleCycle();
        tbl_chk = 0;

        checkOutput("queue_drain", q0.size() + q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
